// File: rtl/ascon_pkg.sv
// Shared constants, types and helpers for the sequenced Ascon permutation engine.
package ascon_pkg;
   localparam int LANE_W    = 64;
   localparam int NUM_LANES = 5;
   localparam int STATE_W   = NUM_LANES * LANE_W;
   localparam int NUM_RND   = 12;

   localparam logic [3:0] RND_12 = 4'd12;
   localparam logic [3:0] RND_8  = 4'd8;
   localparam logic [3:0] RND_6  = 4'd6;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   // x0 occupies the MSBs of the flat state vector
   typedef struct packed {
      logic [LANE_W-1:0] x0;
      logic [LANE_W-1:0] x1;
      logic [LANE_W-1:0] x2;
      logic [LANE_W-1:0] x3;
      logic [LANE_W-1:0] x4;
   } ascon_state_t;

   function automatic int lane_lo(input int k);
      return STATE_W - LANE_W * (k + 1);
   endfunction

   function automatic logic [LANE_W-1:0] rc(input logic [3:0] i);
      return {56'h0, 4'hF - i, i};
   endfunction

   function automatic logic [LANE_W-1:0] ror(input logic [LANE_W-1:0] v, input int unsigned n);
      return (v >> n) | (v << (LANE_W - n));
   endfunction
endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
   import ascon_pkg::*;
(
   input  logic [3:0]         idx,
   input  logic [STATE_W-1:0] s_in,
   output logic [STATE_W-1:0] s_out
);
   ascon_state_t a, b, c;
   logic [LANE_W-1:0] t0, t1, t2, t3, t4;

   always_comb begin
      a    = s_in;
      a.x2 = a.x2 ^ rc(idx);

      b    = a;
      b.x0 = b.x0 ^ b.x4;
      b.x4 = b.x4 ^ b.x3;
      b.x2 = b.x2 ^ b.x1;
      t0   = ~b.x0 & b.x1;
      t1   = ~b.x1 & b.x2;
      t2   = ~b.x2 & b.x3;
      t3   = ~b.x3 & b.x4;
      t4   = ~b.x4 & b.x0;
      b.x0 = b.x0 ^ t1;
      b.x1 = b.x1 ^ t2;
      b.x2 = b.x2 ^ t3;
      b.x3 = b.x3 ^ t4;
      b.x4 = b.x4 ^ t0;
      b.x1 = b.x1 ^ b.x0;
      b.x0 = b.x0 ^ b.x4;
      b.x3 = b.x3 ^ b.x2;
      b.x2 = ~b.x2;

      c.x0 = b.x0 ^ ror(b.x0, 19) ^ ror(b.x0, 28);
      c.x1 = b.x1 ^ ror(b.x1, 61) ^ ror(b.x1, 39);
      c.x2 = b.x2 ^ ror(b.x2, 1)  ^ ror(b.x2, 6);
      c.x3 = b.x3 ^ ror(b.x3, 10) ^ ror(b.x3, 17);
      c.x4 = b.x4 ^ ror(b.x4, 7)  ^ ror(b.x4, 41);
      s_out = c;
   end
endmodule

// File: rtl/ascon_p_engine.sv
// Multi-cycle Ascon p^a engine with valid/ready in and out; UNROLL rounds per clock.
module ascon_p_engine
   import ascon_pkg::*;
#(
   parameter int BW     = 64,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5*BW-1:0] in_state,
   input  logic [3:0]      in_rounds,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5*BW-1:0] out_state,
   output logic            busy,
   output logic            err
);
   fsm_t                        fsm;
   logic [STATE_W-1:0]          st_q;
   logic [3:0]                  idx_q;
   logic [UNROLL:0][STATE_W-1:0] chain;
   logic                        rdy, acc, legal;
   logic [3:0]                  start;
   logic [4:0]                  nxt_idx;

   assign legal   = in_rounds inside {RND_12, RND_8, RND_6};
   assign start   = legal ? (4'd12 - in_rounds) : 4'd0;
   assign nxt_idx = {1'b0, idx_q} + 5'(UNROLL);

   // A finishing result and a new request can trade places in the same cycle
   assign rdy       = (fsm == IDLE) | ((fsm == DONE) & out_ready);
   assign acc       = in_valid & rdy;
   assign in_ready  = rstn & rdy;
   assign out_state = st_q;

   assign chain[0] = st_q;
   for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
      ascon_round u_round (
         .idx   (idx_q + 4'(g)),
         .s_in  (chain[g]),
         .s_out (chain[g+1])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fsm       <= IDLE;
         st_q      <= '0;
         idx_q     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         unique case (fsm)
            IDLE, DONE: begin
               if (acc) begin
                  st_q      <= in_state;
                  idx_q     <= start;
                  err       <= ~legal;
                  fsm       <= RUN;
                  out_valid <= 1'b0;
                  busy      <= 1'b1;
               end else if ((fsm == DONE) && out_ready) begin
                  fsm       <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            RUN: begin
               st_q  <= chain[UNROLL];
               idx_q <= nxt_idx[3:0];
               if (nxt_idx >= 5'(NUM_RND)) begin
                  fsm       <= DONE;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ascon_p_engine.sv
// Directed bench for ascon_p_engine: UNROLL=1 and UNROLL=2 instances against a column-wise S-box model.
module tb_ascon_p_engine;
   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [319:0] in_state = '0;
   logic [3:0]   in_rounds = 4'd0;
   logic         sel = 1'b0;

   logic         iv1, iv2, ir1, ir2, ov1, ov2, bz1, bz2, er1, er2;
   logic [319:0] os1, os2;
   logic         ir, ov, bz, er;
   logic [319:0] os;

   int n_chk = 0;
   int n_fail = 0;

   logic [4:0] SBOX [0:31] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                               5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                               5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                               5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   always #5 clk = ~clk;

   assign iv1 = in_valid & ~sel;
   assign iv2 = in_valid & sel;
   assign ir  = sel ? ir2 : ir1;
   assign ov  = sel ? ov2 : ov1;
   assign bz  = sel ? bz2 : bz1;
   assign er  = sel ? er2 : er1;
   assign os  = sel ? os2 : os1;

   ascon_p_engine #(.BW(64), .UNROLL(1)) u_e1 (
      .clk(clk), .rstn(rstn), .in_valid(iv1), .in_ready(ir1), .in_state(in_state),
      .in_rounds(in_rounds), .out_valid(ov1), .out_ready(out_ready), .out_state(os1),
      .busy(bz1), .err(er1));

   ascon_p_engine #(.BW(64), .UNROLL(2)) u_e2 (
      .clk(clk), .rstn(rstn), .in_valid(iv2), .in_ready(ir2), .in_state(in_state),
      .in_rounds(in_rounds), .out_valid(ov2), .out_ready(out_ready), .out_state(os2),
      .busy(bz2), .err(er2));

   task automatic chk_v(input string nm, input logic [319:0] act, input logic [319:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_b(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] rr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Reference: S-box applied one bit column at a time through the lookup table
   function automatic logic [319:0] perm(input logic [319:0] s, input int first, input int n);
      logic [63:0] x [5];
      logic [4:0]  v, y;
      for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
      for (int r = first; r < first + n; r++) begin
         x[2] = x[2] ^ 64'((15 - r) * 16 + r);
         for (int b = 0; b < 64; b++) begin
            v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            y = SBOX[v];
            x[0][b] = y[4]; x[1][b] = y[3]; x[2][b] = y[2]; x[3][b] = y[1]; x[4][b] = y[0];
         end
         x[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
         x[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
         x[2] = x[2] ^ rr(x[2], 1)  ^ rr(x[2], 6);
         x[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
         x[4] = x[4] ^ rr(x[4], 7)  ^ rr(x[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   function automatic logic [319:0] rnd320();
      logic [319:0] r;
      for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom();
      return r;
   endfunction

   // Transaction-level expectation: a pending job becomes visible after a/UNROLL edges
   bit           m_pend = 1'b0;
   int           m_rem = 0;
   logic [319:0] m_res = '0;
   bit           m_err = 1'b0;

   always @(posedge clk) begin
      bit e_ov, e_ir, lg;
      int a_eff;
      if (!rstn) begin
         m_pend = 1'b0;
         m_err  = 1'b0;
      end else begin
         e_ov  = m_pend && (m_rem == 0);
         e_ir  = !m_pend || (e_ov && out_ready);
         m_err = 1'b0;
         if (m_pend && m_rem > 0) m_rem--;
         else if (e_ov && out_ready) m_pend = 1'b0;
         if (in_valid && e_ir) begin
            lg     = (in_rounds == 4'd12) || (in_rounds == 4'd8) || (in_rounds == 4'd6);
            a_eff  = lg ? int'(in_rounds) : 12;
            m_pend = 1'b1;
            m_rem  = a_eff / (sel ? 2 : 1);
            m_res  = perm(in_state, 12 - a_eff, a_eff);
            m_err  = !lg;
         end
      end
   end

   always @(negedge clk) begin
      bit e_ov, e_busy, e_ir;
      e_ov   = rstn && m_pend && (m_rem == 0);
      e_busy = rstn && m_pend && (m_rem > 0);
      e_ir   = rstn && (!m_pend || (e_ov && out_ready));
      chk_b("out_valid", ov, e_ov);
      chk_b("busy", bz, e_busy);
      chk_b("in_ready", ir, e_ir);
      chk_b("err", er, rstn && m_err);
      if (e_ov) chk_v("out_state", os, m_res);
      else if (!rstn) chk_v("out_state_rst", os, '0);
   end

   // Returns at the negedge where out_valid is seen (or the budget runs out)
   task automatic wait_ov(input bit do_probe, input logic [7:0] exp_rc, input int exp_lat);
      int lat;
      logic [3:0] p;
      logic [7:0] rcv;
      @(negedge clk);
      if (do_probe) begin
         p   = sel ? u_e2.g_rnd[0].u_round.idx : u_e1.g_rnd[0].u_round.idx;
         rcv = {4'hF - p, p};
         chk_v("first_rc", 320'(rcv), 320'(exp_rc));
      end
      lat = 0;
      while (!ov && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk_v("latency", 320'(lat), 320'(exp_lat));
   endtask

   // Called just after a rising edge
   task automatic job(input logic [319:0] s, input logic [3:0] a, input int exp_lat,
                      input logic [7:0] exp_rc, input bit hold);
      logic [319:0] snap;
      in_valid  = 1'b1;
      in_state  = s;
      in_rounds = a;
      out_ready = !hold;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_rounds = 4'($urandom_range(0, 15));
      in_state  = rnd320();
      wait_ov(1'b1, exp_rc, exp_lat);
      if (hold) begin
         snap = os;
         repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk_v("hold_state", os, snap);
            chk_b("hold_valid", ov, 1'b1);
            chk_b("hold_in_ready", ir, 1'b0);
         end
         #1 out_ready = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic suite(input logic s_unroll2);
      int u;
      logic [319:0] s1, s2;
      sel = s_unroll2;
      u   = s_unroll2 ? 2 : 1;
      job('0, 4'd12, 12 / u, 8'hF0, 1'b0);
      job(rnd320(), 4'd8, 8 / u, 8'hB4, 1'b0);
      job(rnd320(), 4'd6, 6 / u, 8'h96, 1'b0);
      job(rnd320(), 4'd12, 12 / u, 8'hF0, 1'b1);
      job(rnd320(), 4'd5, 12 / u, 8'hF0, 1'b0);
      job(rnd320(), 4'd0, 12 / u, 8'hF0, 1'b0);

      // Back-to-back handoff in DONE
      s1 = rnd320();
      s2 = rnd320();
      in_valid = 1'b1; in_state = s1; in_rounds = 4'd12; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      wait_ov(1'b0, 8'h00, 12 / u);
      #1 in_valid = 1'b1; in_state = s2; in_rounds = 4'd12;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk_b("b2b_busy", bz, 1'b1);
      chk_b("b2b_no_bubble", ov, 1'b0);
      wait_ov(1'b0, 8'h00, 12 / u - 1);
      @(posedge clk); #1;

      // Reset in the middle of a run drops the job
      in_valid = 1'b1; in_state = rnd320(); in_rounds = 4'd12; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (14) begin
         @(negedge clk);
         chk_b("rst_no_valid", ov, 1'b0);
      end
      @(posedge clk); #1;
      job(rnd320(), 4'd12, 12 / u, 8'hF0, 1'b0);
   endtask

   initial begin
      logic [319:0] r1;
      // Pin the model: one round on the all-zero state, worked by hand
      r1 = perm('0, 0, 1);
      chk_v("model_x0", 320'(r1[319:256]), 320'(64'h001E0F00000000F0));
      chk_v("model_x1", 320'(r1[255:192]), 320'(64'h00000001E0000770));
      chk_v("model_x2", 320'(r1[191:128]), 320'(64'h3FFFFFFFFFFFFF74));
      chk_v("model_x3", 320'(r1[127:64]),  320'(64'h3C780000000000F0));
      chk_v("model_x4", 320'(r1[63:0]),    320'(64'h0));

      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      suite(1'b0);
      repeat (2) @(posedge clk);
      #1;
      suite(1'b1);
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
